// File: rtl/cpu_debug_monitor.sv
// cpu_debug_monitor: self-check and trace monitor that sits beside cpu_top.
// Taps the retire stream and the register-file write port. Keeps a circular
// trace buffer and shadows one result register. Ends the run on a cycle budget
// or on a halt loop, then reports pass/fail.
// Optional feature macro: DBGMON_BRANCH_STATS_EN builds the taken/not-taken
// branch counters. When it is undefined, both counter ports read 0.
module cpu_debug_monitor #(
  parameter int              XLEN        = 32,
  parameter int              DEPTH       = 16,
  parameter int              CHECK_REG   = 10,
  parameter logic [XLEN-1:0] EXPECT_VAL  = XLEN'(10),
  parameter int              MAX_CYCLES  = 40,
  parameter int              HALT_CYCLES = 4
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             retire_valid,
  input  logic [XLEN-1:0]                  retire_pc,
  input  logic [31:0]                      retire_instr,
  input  logic                             branch,
  input  logic                             zero,
  input  logic                             rf_we,
  input  logic [4:0]                       rf_waddr,
  input  logic [XLEN-1:0]                  rf_wdata,
  input  logic                             trace_rd_en,
  output logic                             trace_rd_valid,
  output logic [XLEN+32:0]                 trace_rd_data,
  output logic [$clog2(DEPTH):0]           trace_count,
  output logic                             trace_ovf,
  output logic                             done,
  output logic                             pass,
  output logic                             halted,
  output logic [$clog2(MAX_CYCLES+1)-1:0]  cycle_count,
  output logic [15:0]                      br_taken_cnt,
  output logic [15:0]                      br_ntaken_cnt
);

  localparam int PTR_W   = $clog2(DEPTH);
  localparam int CNT_W   = PTR_W + 1;
  localparam int CYC_W   = $clog2(MAX_CYCLES + 1);
  localparam int SAME_W  = $clog2(HALT_CYCLES + 1);
  localparam int ENTRY_W = XLEN + 33;

  localparam logic [CNT_W-1:0]  DEPTH_C    = CNT_W'(DEPTH);
  localparam logic [CYC_W-1:0]  LAST_CYCLE = CYC_W'(MAX_CYCLES - 1);
  localparam logic [SAME_W-1:0] HALT_LAST  = SAME_W'(HALT_CYCLES - 1);
  localparam logic [4:0]        CHECK_IDX  = 5'(CHECK_REG);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t state;
  state_t state_next;

  logic [ENTRY_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]   wr_ptr;
  logic [PTR_W-1:0]   rd_ptr;

  logic [XLEN-1:0]    shadow;
  logic [XLEN-1:0]    shadow_next;
  logic [XLEN-1:0]    prev_pc;
  logic               prev_valid;
  logic [SAME_W-1:0]  same_cnt;

  logic               active;
  logic               push;
  logic               pop;
  logic               full;
  logic               shadow_hit;
  logic               same_pc;
  logic               halt_hit;
  logic               budget_hit;
  logic [ENTRY_W-1:0] push_entry;

  // Capture, shadow and stats are live only before the run has finished.
  assign active      = (state != S_DONE);
  assign push        = retire_valid && active;
  assign full        = (trace_count == DEPTH_C);
  assign pop         = trace_rd_en && (trace_count != '0);
  assign push_entry  = {branch & zero, retire_instr, retire_pc};
  assign shadow_hit  = rf_we && (rf_waddr == CHECK_IDX) && (rf_waddr != 5'd0);
  assign shadow_next = (active && shadow_hit) ? rf_wdata : shadow;
  assign same_pc     = retire_valid && prev_valid && (retire_pc == prev_pc);
  assign halt_hit    = (state == S_RUN) && same_pc && (same_cnt == HALT_LAST);
  assign budget_hit  = (state == S_RUN) && (cycle_count == LAST_CYCLE);

  // State register for the run-control FSM.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic: the first retire starts the run, halt or budget ends it.
  always_comb begin
    state_next = state;
    case (state)
      S_IDLE: begin
        if (retire_valid) begin
          state_next = S_RUN;
        end
      end
      S_RUN: begin
        if (halt_hit || budget_hit) begin
          state_next = S_DONE;
        end
      end
      S_DONE: begin
        state_next = S_DONE;
      end
      default: begin
        state_next = S_IDLE;
      end
    endcase
  end

  // Halt detector: counts back-to-back retires that repeat the previous PC.
  always_ff @(posedge clk) begin
    if (rst) begin
      prev_pc    <= '0;
      prev_valid <= 1'b0;
      same_cnt   <= '0;
    end else if (push) begin
      prev_pc    <= retire_pc;
      prev_valid <= 1'b1;
      same_cnt   <= same_pc ? (same_cnt + SAME_W'(1)) : '0;
    end
  end

  // Shadow register, run-cycle counter and the final verdict latched on entering DONE.
  always_ff @(posedge clk) begin
    if (rst) begin
      shadow      <= '0;
      cycle_count <= '0;
      done        <= 1'b0;
      pass        <= 1'b0;
      halted      <= 1'b0;
    end else begin
      shadow <= shadow_next;
      if (state == S_RUN) begin
        cycle_count <= cycle_count + CYC_W'(1);
      end
      if ((state == S_RUN) && (state_next == S_DONE)) begin
        done   <= 1'b1;
        pass   <= (shadow_next == EXPECT_VAL);
        halted <= halt_hit;
      end
    end
  end

  // Trace storage: a push writes at wr_ptr and overwrites the oldest entry when full.
  always_ff @(posedge clk) begin
    if (push && !rst) begin
      mem[wr_ptr] <= push_entry;
    end
  end

  // Trace pointers and occupancy; a push into a full buffer without a pop drops the oldest entry.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      trace_count <= '0;
      trace_ovf   <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (pop || (push && full)) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      if (push && !pop && !full) begin
        trace_count <= trace_count + CNT_W'(1);
      end else if (pop && !push) begin
        trace_count <= trace_count - CNT_W'(1);
      end
      if (push && full && !pop) begin
        trace_ovf <= 1'b1;
      end
    end
  end

  // Read port: the oldest entry appears one cycle after an accepted pop; data holds otherwise.
  always_ff @(posedge clk) begin
    if (rst) begin
      trace_rd_valid <= 1'b0;
      trace_rd_data  <= '0;
    end else begin
      trace_rd_valid <= pop;
      if (pop) begin
        trace_rd_data <= mem[rd_ptr];
      end
    end
  end

`ifdef DBGMON_BRANCH_STATS_EN
  // Branch statistics: saturating taken / not-taken counters over captured retires.
  always_ff @(posedge clk) begin
    if (rst) begin
      br_taken_cnt  <= '0;
      br_ntaken_cnt <= '0;
    end else if (push && branch) begin
      if (zero) begin
        if (br_taken_cnt != 16'hFFFF) begin
          br_taken_cnt <= br_taken_cnt + 16'd1;
        end
      end else begin
        if (br_ntaken_cnt != 16'hFFFF) begin
          br_ntaken_cnt <= br_ntaken_cnt + 16'd1;
        end
      end
    end
  end
`else
  assign br_taken_cnt  = '0;
  assign br_ntaken_cnt = '0;
`endif

endmodule
